mp_add_seq: RTL
===============

# mp_add_seq

Multi-precision add/subtract sequencer that sits directly upstream of `p_adder`. It accepts operand packets of 32-bit words, least-significant word first, over a valid/ready stream. It drives one word pair per cycle into an internal `p_adder` instance, chaining carry between words, and registers each 32-bit result word onto an output stream, with the final carry/borrow delivered on the last word.

## Interface
Parameters:
- `MAX_WORDS`, default 8: maximum words per packet; range 1..255.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `in_valid`  in  1  input word pair valid.
- `in_ready`  out  1  block accepts the input word pair this cycle.
- `in_a`  in  32  operand A word.
- `in_b`  in  32  operand B word.
- `in_last`  in  1  most-significant word of the packet.
- `in_sub`  in  1  packet operation, 0 = A+B, 1 = A−B; sampled on the first word only.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  downstream accepts the result word.
- `out_s`  out  32  result word.
- `out_last`  out  1  last result word of the packet.
- `out_cout`  out  1  final carry (add) or no-borrow (sub); meaningful only with `out_last`.
- `err_len`  out  1  sticky flag: a packet hit `MAX_WORDS` without `in_last`.

## Operation
- Internal `p_adder` ports are driven as follows:
  - `a` = `in_a`.
  - `b` = `in_b`, or `~in_b` when the packet is a subtract.
  - `cin` = `first_q ? op : carry_q`, where `op` is `in_sub` on the first word and `sub_q` on later words.
- Registers:
  - `first_q`: reset 1.
  - `carry_q`: reset 0.
  - `sub_q`: reset 0.
  - `cnt_q`: 8 bits, reset 0.
  - Output register (`out_s`, `out_last`, `out_cout`): reset 0.
  - `out_valid`: reset 0.
  - `err_len`: reset 0.
- Accept event `acc = in_valid && in_ready`.
  - Output register loads `p_adder.s`.
  - `carry_q` loads `p_adder.cout`.
  - `cnt_q` increments.
  - On the first word, `sub_q` loads `in_sub`.
- Effective last: `eff_last = in_last || (cnt_q == MAX_WORDS-1)`.
  - On an accept with `eff_last`: `out_last` = 1, `out_cout` = `p_adder.cout`.
  - Then `first_q` returns to 1, `cnt_q` to 0, `carry_q` to 0.
- Forced end of packet: if `eff_last` is true but `in_last` = 0, the packet is terminated at that word and `err_len` sets.
  - Later words are treated as a new packet.
  - `err_len` clears only on reset.
- States, implicit in `first_q`:
  - IDLE/FIRST (`first_q` = 1) → MID on an accept without `eff_last`.
  - MID → FIRST on an accept with `eff_last`.
  - A single-word packet stays in FIRST.
- Arithmetic is modulo 2^(32·N) for an N-word packet.
- For subtract, `out_cout` = 1 means A ≥ B (unsigned).

## Timing
- Latency: an accepted word appears on `out_*` at the next rising edge, i.e. 1 cycle.
- `in_ready = !out_valid || out_ready`, a combinational pass-through of `out_ready`.
  - Full throughput is 1 word per cycle while the downstream is ready.
- `out_valid` behaviour:
  - Sets on `acc`.
  - Clears when `out_valid && out_ready && !acc`.
  - Holds when `out_ready` = 0.
- While `out_valid && !out_ready`:
  - `out_s`, `out_last` and `out_cout` are stable.
  - `in_ready` = 0.
- Output fire and new accept in the same cycle: the output register reloads and `out_valid` stays 1.
- Reset mid-packet: all registers return to their reset values at the sampled edge.
  - The in-flight output word is dropped.
  - The next accepted word is treated as a packet's first word.
- `in_*` and `in_sub` are don't-care when `in_valid` = 0.

## Configuration
- `MP_ADD_SUB_EN` defined:
  - Subtract mode is built in as described above.
- Not defined:
  - `in_sub` is ignored, `sub_q` is not implemented, B is never inverted and the first-word `cin` = 0.
  - The block is add-only; the port list is unchanged.

## Test plan
- Single-word add: A=0x00000001, B=0x00000001, `in_last`=1 → next cycle `out_s`=0x00000002, `out_last`=1, `out_cout`=0.
- Two-word carry chain: words (0xFFFFFFFF, 0x00000001), then (0x00000000, 0x00000000, last) → `out_s` 0x00000000, then 0x00000001 with `out_last`=1, `out_cout`=0.
- Subtract (`MP_ADD_SUB_EN`): one word, A=0x10101010, B=0x00110101, `in_sub`=1 → `out_s`=0x0FFF0F0F, `out_cout`=1.
- Subtract with borrow: A=0, B=1, `in_sub`=1 → `out_s`=0xFFFFFFFF, `out_cout`=0.
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `out_*` stable, no word lost or duplicated after release.
- Length overflow: `MAX_WORDS`=2, three words with no `in_last` → the second result has `out_last`=1, `err_len`=1, and the third word starts a new packet with `cin`=0.

Source files
------------

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer feeding an internal p_adder, one 32-bit word per cycle.
// Define MP_ADD_SUB_EN to build in subtract mode; without it the block is add-only.

module p_adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

module mp_add_seq #(
   parameter int MAX_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        in_last,
   input  logic        in_sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_s,
   output logic        out_last,
   output logic        out_cout,
   output logic        err_len
);

   localparam logic [7:0] LAST_CNT = 8'(MAX_WORDS - 1);

   logic        first_q;
   logic        carry_q;
   logic [7:0]  cnt_q;
   logic        acc;
   logic        eff_last;
   logic [31:0] add_b;
   logic        add_cin;
   logic [31:0] add_s;
   logic        add_cout;

   assign in_ready = !out_valid || out_ready;
   assign acc      = in_valid && in_ready;
   assign eff_last = in_last || (cnt_q == LAST_CNT);

`ifdef MP_ADD_SUB_EN
   logic sub_q;
   logic op;

   // The operation is taken from the port on a packet's first word and held for the rest.
   assign op      = first_q ? in_sub : sub_q;
   assign add_b   = op ? ~in_b : in_b;
   assign add_cin = first_q ? op : carry_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         sub_q <= 1'b0;
      else if (acc && first_q)
         sub_q <= in_sub;
   end
`else
   logic unused_sub;

   assign unused_sub = in_sub;
   assign add_b      = in_b;
   assign add_cin    = first_q ? 1'b0 : carry_q;
`endif

   p_adder u_adder (
      .a    (in_a),
      .b    (add_b),
      .cin  (add_cin),
      .s    (add_s),
      .cout (add_cout)
   );

   // Every packet boundary, natural or forced by the length limit, restarts the carry chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         first_q   <= 1'b1;
         carry_q   <= 1'b0;
         cnt_q     <= 8'd0;
         out_valid <= 1'b0;
         out_s     <= 32'd0;
         out_last  <= 1'b0;
         out_cout  <= 1'b0;
         err_len   <= 1'b0;
      end else if (acc) begin
         out_valid <= 1'b1;
         out_s     <= add_s;
         out_last  <= eff_last;
         out_cout  <= eff_last ? add_cout : 1'b0;
         if (eff_last) begin
            first_q <= 1'b1;
            carry_q <= 1'b0;
            cnt_q   <= 8'd0;
            if (!in_last)
               err_len <= 1'b1;
         end else begin
            first_q <= 1'b0;
            carry_q <= add_cout;
            cnt_q   <= cnt_q + 8'd1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
